// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer: state encodings,
// colour constants and default gameplay tuning.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_FLASH = 12'hFF0;
  localparam logic [11:0] COL_OVER  = 12'hF00;

  localparam int DEF_HIT_RADIUS      = 10;
  localparam int DEF_MAX_HITS        = 5;
  localparam int DEF_COOLDOWN_FRAMES = 60;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] r_val;
  logic [15:0] w_next;
  logic        w_carry;

  // Ripple the increment upward through the digits; hold once all are 9.
  always_comb begin
    w_next  = r_val;
    w_carry = 1'b1;
    if (r_val != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (w_carry) begin
          if (r_val[i*4 +: 4] == 4'd9) begin
            w_next[i*4 +: 4] = 4'd0;
          end else begin
            w_next[i*4 +: 4] = r_val[i*4 +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= 16'h0000;
    end else if (clr) begin
      r_val <= 16'h0000;
    end else if (inc) begin
      r_val <= w_next;
    end
  end

  assign value = r_val;

endmodule

// File: rtl/game_sequencer.sv
// Round controller: sequences idle/play/hit/over, checks sprite overlap once
// per frame, counts hits, keeps a BCD survival score and arbitrates the pixel.
module game_sequencer
  import game_pkg::*;
#(
  parameter int          HIT_RADIUS      = DEF_HIT_RADIUS,
  parameter int          MAX_HITS        = DEF_MAX_HITS,
  parameter int          COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter logic [11:0] FLASH_COLOR     = COL_FLASH,
  parameter logic [11:0] OVER_COLOR      = COL_OVER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        bright,
  input  logic [9:0]  xpos1,
  input  logic [9:0]  ypos1,
  input  logic [9:0]  xpos2,
  input  logic [9:0]  ypos2,
  input  logic [11:0] rgb1,
  input  logic [11:0] rgb2,
  input  logic [11:0] bg2,
  output logic        move_en,
  output logic        collision,
  output logic [2:0]  hits,
  output logic [15:0] score_bcd,
  output logic [11:0] pix_out,
  output logic [1:0]  state_o
);

  localparam int       CD_W     = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [2:0] LAST_HIT = 3'(MAX_HITS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_hits;
  logic [CD_W-1:0] r_cooldown;
  logic            r_flash;
  logic            r_collision;
  logic [11:0]     r_pix;
  logic            w_overlap;
  logic            w_hit_evt;
  logic            w_clr;
  logic            w_inc;

  // Absolute differences are formed in 11 bits by subtracting the smaller
  // coordinate from the larger, so no operand ordering can wrap.
  function automatic logic f_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] bx, input logic [9:0] by);
    logic [10:0] dx;
    logic [10:0] dy;
    dx = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
    dy = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
    return (dx <= 11'(HIT_RADIUS)) && (dy <= 11'(HIT_RADIUS));
  endfunction

  assign w_overlap = f_overlap(xpos1, ypos1, xpos2, ypos2);

  always_comb begin
    w_state_nxt = r_state;
    w_hit_evt   = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_state_nxt = PLAY;
          w_clr       = 1'b1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          w_inc = 1'b1;
          if (w_overlap) begin
            w_hit_evt   = 1'b1;
            w_state_nxt = (r_hits == LAST_HIT) ? OVER : HIT;
          end
        end
      end
      HIT: begin
        if (frame_tick) begin
          w_inc = 1'b1;
          if (r_cooldown == CD_W'(1)) w_state_nxt = PLAY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hits      <= 3'd0;
      r_cooldown  <= '0;
      r_flash     <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_collision <= w_hit_evt;
      if (w_clr) begin
        r_hits     <= 3'd0;
        r_cooldown <= '0;
        r_flash    <= 1'b0;
      end else if (w_hit_evt) begin
        r_hits <= r_hits + 3'd1;
        if (w_state_nxt == HIT) begin
          r_cooldown <= CD_W'(COOLDOWN_FRAMES);
          r_flash    <= 1'b1;
        end
      end else if ((r_state == HIT) && frame_tick) begin
        r_cooldown <= r_cooldown - CD_W'(1);
        // Leave the flash off when the cooldown expires.
        r_flash    <= (r_cooldown == CD_W'(1)) ? 1'b0 : ~r_flash;
      end
    end
  end

  // Pixel arbitration uses the registered state, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= COL_BLACK;
    end else if (!bright) begin
      r_pix <= COL_BLACK;
    end else if (r_state == OVER) begin
      r_pix <= OVER_COLOR;
    end else if ((r_state == HIT) && r_flash) begin
      r_pix <= FLASH_COLOR;
    end else if (rgb2 != bg2) begin
      r_pix <= rgb2;
    end else begin
      r_pix <= rgb1;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_inc),
    .value (score_bcd)
  );

  assign move_en   = (r_state == PLAY) || (r_state == HIT);
  assign collision = r_collision;
  assign hits      = r_hits;
  assign pix_out   = r_pix;
  assign state_o   = r_state;

endmodule
